fx_bus_arb: RTL and testbench
=============================

FX_BUS_ARB -- requirements
Module: fx_bus_arb

Interface
- REQ-001 SHALL have parameter RD_LAT, default 1, giving the cycles from fx_rd high to valid fx_q; legal range 1..7.
- REQ-002 SHALL have port clk_sys, input, 1 bit: the single clock; all flops are on its rising edge.
- REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
- REQ-004 SHALL have ports a_req/b_req, input, 1 bit each: requester A/B access request, held until the matching ack.
- REQ-005 SHALL have ports a_we/b_we, input, 1 bit each: 1 = write, 0 = read; valid while req is high.
- REQ-006 SHALL have ports a_addr/b_addr, input, 22 bits each: access address.
- REQ-007 SHALL have ports a_wdata/b_wdata, input, 8 bits each: write data.
- REQ-008 SHALL have ports a_ack/b_ack, output, 1 bit each: one-cycle completion pulse.
- REQ-009 SHALL have ports a_rdata/b_rdata, output, 8 bits each: read data, valid in the ack cycle and held until that requester's next read completes.
- REQ-010 SHALL have ports fx_wr and fx_rd, output, 1 bit each; fx_waddr and fx_raddr, output, 22 bits each; fx_data, output, 8 bits: the cfg-register bus drive.
- REQ-011 SHALL have port fx_q, input, 8 bits: cfg-register read data.
- REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
- REQ-013 SHALL implement the states IDLE, WRITE, READ, WAIT and DONE.
- REQ-014 SHALL, in IDLE with any req high, grant one requester and latch its we, addr and wdata; the next state is WRITE if we=1, else READ.
- REQ-015 SHALL arbitrate round-robin: when both requests are high, grant the requester not served last; the last-served pointer resets to B, so A wins the first tie.
- REQ-016 SHALL, with only one req high, grant that requester regardless of the pointer; the pointer updates on every grant.
- REQ-017 SHALL, in WRITE, assert fx_wr for exactly one cycle with fx_waddr/fx_data equal to the latched values, then go to DONE.
- REQ-018 SHALL, in READ, assert fx_rd for exactly one cycle with fx_raddr equal to the latched address, then go to WAIT.
- REQ-019 SHALL stay in WAIT for RD_LAT cycles using a 3-bit counter, capture fx_q into the granted requester's rdata register at the end of the last WAIT cycle, then go to DONE.
- REQ-020 SHALL, in DONE, pulse the granted requester's ack for one cycle, then return to IDLE.
- REQ-021 SHALL give a write latency (grant cycle to ack cycle inclusive) of 3 cycles and a read latency of 3+RD_LAT cycles; with RD_LAT=1 that is IDLE, READ, WAIT, DONE.
- REQ-022 SHALL not sample req outside IDLE; a request arriving mid-transfer waits.
- REQ-023 SHALL re-arbitrate a req still high in the IDLE cycle after ack as a new request; requesters drop req on the ack edge.
- REQ-024 SHALL hold fx_waddr, fx_raddr and fx_data at their last latched values when not strobing.
- REQ-025 SHALL never assert fx_wr and fx_rd together, and never ack both requesters in one cycle.
- REQ-026 SHALL leave the other requester's rdata unchanged on any access.
- REQ-027 SHALL ignore changes to the granted requester's we/addr/wdata after the grant cycle.

Reset
- REQ-028 SHALL, while rst_n=0, force: state IDLE; the pointer to B; the WAIT counter, fx_wr, fx_rd, fx_waddr, fx_raddr, fx_data, a_ack, b_ack, a_rdata, b_rdata and busy all to 0.
- REQ-029 SHALL, on reset asserted mid-transfer, abort the transfer immediately with no ack and no strobe; after release the block restarts in IDLE.

Verification
- REQ-030 SHALL check a single write: A writes addr 0x000010, data 0x5A -> fx_wr high for 1 cycle, 1 cycle after grant, with fx_waddr=0x000010 and fx_data=0x5A; a_ack 2 cycles after grant.
- REQ-031 SHALL check a single read: B reads addr 0x000020 while the model returns 0xC3 RD_LAT after fx_rd -> b_rdata=0xC3 in the b_ack cycle; a_rdata unchanged.
- REQ-032 SHALL check a simultaneous request: A and B requesting from reset -> A served first, then B; repeated continuous requests alternate A, B, A, B.
- REQ-033 SHALL check a late request: B's req rises during A's WAIT -> B is granted in the first IDLE after a_ack, with no overlap of strobes.
- REQ-034 SHALL check reset mid-transfer: rst_n low during READ -> fx_rd=0, no ack, busy=0; after release a new A write completes normally.
- REQ-035 SHALL run a RD_LAT=3 build: read latency is exactly 6 cycles and data is captured from the correct fx_q cycle.

Source files
------------

// File: rtl/fx_bus_arb.sv
// fx_bus_arb: two-requester round-robin arbiter onto the cfg-register bus.
// One transfer at a time. Writes take a single fx_wr strobe. Reads take a
// single fx_rd strobe, then RD_LAT wait cycles, then fx_q is captured.
// Every transfer ends with a one-cycle ack to the requester that was granted.
module fx_bus_arb #(
    parameter int RD_LAT = 1
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [21:0] a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_ack,
    output logic [7:0]  a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [21:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_ack,
    output logic [7:0]  b_rdata,
    output logic        fx_wr,
    output logic        fx_rd,
    output logic [21:0] fx_waddr,
    output logic [21:0] fx_raddr,
    output logic [7:0]  fx_data,
    input  logic [7:0]  fx_q,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Index of the final WAIT cycle; fx_q is valid during that cycle.
    localparam logic [2:0] LAST_WAIT = 3'(RD_LAT - 1);

    state_t      state;
    logic        last_b;    // 1: B was the last requester served
    logic        sel_b;     // requester that owns the current transfer
    logic [2:0]  wait_cnt;

    logic        pick_b;
    logic        pick_we;
    logic [21:0] pick_addr;
    logic [7:0]  pick_wdata;

    // Grant decode. A lone request always wins. On a tie, the requester
    // that was not served last wins.
    always_comb begin
        pick_b     = b_req && (!a_req || !last_b);
        pick_we    = pick_b ? b_we    : a_we;
        pick_addr  = pick_b ? b_addr  : a_addr;
        pick_wdata = pick_b ? b_wdata : a_wdata;
    end

    // Transfer FSM. All bus-side and requester-side outputs are registered.
    // The strobe is raised on the grant edge so it is high during WRITE/READ.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_b   <= 1'b1;
            sel_b    <= 1'b0;
            wait_cnt <= 3'd0;
            fx_wr    <= 1'b0;
            fx_rd    <= 1'b0;
            fx_waddr <= 22'd0;
            fx_raddr <= 22'd0;
            fx_data  <= 8'd0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_rdata  <= 8'd0;
            b_rdata  <= 8'd0;
            busy     <= 1'b0;
        end else begin
            fx_wr <= 1'b0;
            fx_rd <= 1'b0;
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        sel_b  <= pick_b;
                        last_b <= pick_b;
                        busy   <= 1'b1;
                        if (pick_we) begin
                            state    <= WRITE;
                            fx_wr    <= 1'b1;
                            fx_waddr <= pick_addr;
                            fx_data  <= pick_wdata;
                        end else begin
                            state    <= READ;
                            fx_rd    <= 1'b1;
                            fx_raddr <= pick_addr;
                        end
                    end
                end
                WRITE: begin
                    state <= DONE;
                    a_ack <= !sel_b;
                    b_ack <= sel_b;
                end
                READ: begin
                    state    <= WAIT;
                    wait_cnt <= 3'd0;
                end
                WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        if (sel_b) b_rdata <= fx_q;
                        else       a_rdata <= fx_q;
                        a_ack    <= !sel_b;
                        b_ack    <= sel_b;
                        wait_cnt <= 3'd0;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fx_bus_arb.sv
// Bench for fx_bus_arb. The main DUT uses RD_LAT=1 and a second DUT uses
// RD_LAT=3. Each DUT has a bus model that drives fx_q = addr[7:0]^0xE3
// exactly RD_LAT cycles after fx_rd, and 0xEE in every other cycle.
module tb_fx_bus_arb;

    typedef struct {
        logic        port_b;
        logic        we;
        logic [21:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [21:0] a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;
    logic        a_ack, b_ack, fx_wr, fx_rd, busy;
    logic [7:0]  a_rdata, b_rdata, fx_data, fx_q;
    logic [21:0] fx_waddr, fx_raddr;

    // RD_LAT=3 instance, driven only from its A side.
    logic        c_req, c_we;
    logic [21:0] c_addr;
    logic [7:0]  c_wdata;
    logic        c_ack, d_ack, f3_wr, f3_rd, busy3;
    logic [7:0]  c_rdata, d_rdata, f3_data, f3_q;
    logic [21:0] f3_waddr, f3_raddr;

    exp_t sbq[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk_sys = ~clk_sys;

    fx_bus_arb #(.RD_LAT(1)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .fx_wr(fx_wr), .fx_rd(fx_rd), .fx_waddr(fx_waddr), .fx_raddr(fx_raddr),
        .fx_data(fx_data), .fx_q(fx_q), .busy(busy)
    );

    fx_bus_arb #(.RD_LAT(3)) dut3 (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .a_req(c_req), .a_we(c_we), .a_addr(c_addr), .a_wdata(c_wdata),
        .a_ack(c_ack), .a_rdata(c_rdata),
        .b_req(1'b0), .b_we(1'b0), .b_addr(22'd0), .b_wdata(8'd0),
        .b_ack(d_ack), .b_rdata(d_rdata),
        .fx_wr(f3_wr), .fx_rd(f3_rd), .fx_waddr(f3_waddr), .fx_raddr(f3_raddr),
        .fx_data(f3_data), .fx_q(f3_q), .busy(busy3)
    );

    // Bus models: a delay line from fx_rd to valid fx_q.
    logic        p1v;
    logic [21:0] p1a;
    logic [2:0]  p3v;
    logic [21:0] p3a [3];

    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            p1v <= 1'b0;
            p1a <= 22'd0;
            p3v <= 3'd0;
            for (int i = 0; i < 3; i++) p3a[i] <= 22'd0;
        end else begin
            p1v    <= fx_rd;
            p1a    <= fx_raddr;
            p3v    <= {p3v[1:0], f3_rd};
            p3a[0] <= f3_raddr;
            p3a[1] <= p3a[0];
            p3a[2] <= p3a[1];
        end
    end

    assign fx_q = p1v    ? (p1a[7:0]    ^ 8'hE3) : 8'hEE;
    assign f3_q = p3v[2] ? (p3a[2][7:0] ^ 8'hE3) : 8'hEE;

    task automatic test_reset;
        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        repeat (2) @(negedge clk_sys);
        n_cmp++;
        if ({fx_wr, fx_rd, a_ack, b_ack, busy} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got wr/rd/aack/back/busy=%b want 00000", {fx_wr, fx_rd, a_ack, b_ack, busy});
        end
        n_cmp++;
        if (fx_waddr !== 22'd0 || fx_raddr !== 22'd0 || fx_data !== 8'd0 || a_rdata !== 8'd0 || b_rdata !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_data: got waddr=%h raddr=%h data=%h ard=%h brd=%h want all 0", fx_waddr, fx_raddr, fx_data, a_rdata, b_rdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write;
        @(negedge clk_sys);
        a_req = 1; a_we = 1; a_addr = 22'h000010; a_wdata = 8'h5A;
        sbq.push_back('{1'b0, 1'b1, 22'h000010, 8'h5A});
        @(negedge clk_sys);
        n_cmp++;
        if (fx_wr !== 1'b1 || fx_rd !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_strobe: got wr=%b rd=%b busy=%b want 1 0 1", fx_wr, fx_rd, busy);
        end
        n_cmp++;
        if (fx_waddr !== 22'h000010 || fx_data !== 8'h5A) begin
            n_bad++;
            $display("FAIL wr_bus: got waddr=%h data=%h want 000010 5a", fx_waddr, fx_data);
        end
        // changes after the grant must not reach the bus
        a_addr = 22'h3FFFFF; a_wdata = 8'hFF;
        @(negedge clk_sys);
        e = sbq.pop_front();
        n_cmp++;
        if (a_ack !== !e.port_b || b_ack !== e.port_b || fx_wr !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_ack: got aack=%b back=%b wr=%b want %b %b 0", a_ack, b_ack, fx_wr, !e.port_b, e.port_b);
        end
        n_cmp++;
        if (fx_waddr !== e.addr || fx_data !== e.data) begin
            n_bad++;
            $display("FAIL wr_hold: got waddr=%h data=%h want %h %h", fx_waddr, fx_data, e.addr, e.data);
        end
        a_req = 0;
        @(negedge clk_sys);
        n_cmp++;
        if (a_ack !== 1'b0 || busy !== 1'b0 || fx_wr !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_end: got aack=%b busy=%b wr=%b want 0 0 0", a_ack, busy, fx_wr);
        end
    endtask

    task automatic test_read;
        @(negedge clk_sys);
        b_req = 1; b_we = 0; b_addr = 22'h000020;
        sbq.push_back('{1'b1, 1'b0, 22'h000020, 8'hC3});
        @(negedge clk_sys);
        n_cmp++;
        if (fx_rd !== 1'b1 || fx_wr !== 1'b0 || fx_raddr !== 22'h000020) begin
            n_bad++;
            $display("FAIL rd_strobe: got rd=%b wr=%b raddr=%h want 1 0 000020", fx_rd, fx_wr, fx_raddr);
        end
        @(negedge clk_sys);
        n_cmp++;
        if (fx_rd !== 1'b0 || b_ack !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_wait: got rd=%b back=%b busy=%b want 0 0 1", fx_rd, b_ack, busy);
        end
        @(negedge clk_sys);
        e = sbq.pop_front();
        n_cmp++;
        if (b_ack !== e.port_b || a_ack !== !e.port_b || b_rdata !== e.data) begin
            n_bad++;
            $display("FAIL rd_ack: got back=%b aack=%b brd=%h want 1 0 %h", b_ack, a_ack, b_rdata, e.data);
        end
        n_cmp++;
        if (a_rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL rd_other: got ard=%h want 00", a_rdata);
        end
        b_req = 0;
        @(negedge clk_sys);
        n_cmp++;
        if (busy !== 1'b0 || b_ack !== 1'b0 || b_rdata !== 8'hC3) begin
            n_bad++;
            $display("FAIL rd_end: got busy=%b back=%b brd=%h want 0 0 c3", busy, b_ack, b_rdata);
        end
    endtask

    task automatic test_tie;
        logic found;
        @(negedge clk_sys);
        rst_n = 1'b0;
        sbq.delete();
        @(negedge clk_sys);
        rst_n = 1'b1;
        @(negedge clk_sys);
        a_req = 1; a_we = 1; a_addr = 22'h000100; a_wdata = 8'h11;
        b_req = 1; b_we = 1; b_addr = 22'h000200; b_wdata = 8'h22;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) sbq.push_back('{1'b0, 1'b1, 22'h000100, 8'h11});
            else            sbq.push_back('{1'b1, 1'b1, 22'h000200, 8'h22});
        end
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            for (int c = 0; c < 10 && !found; c++) begin
                @(negedge clk_sys);
                if (a_ack || b_ack) found = 1'b1;
            end
            n_cmp++;
            if (!found) begin
                n_bad++;
                $display("FAIL tie_timeout: got no ack for grant %0d want ack within 10 cycles", k);
            end else begin
                e = sbq.pop_front();
                n_cmp++;
                if (a_ack !== !e.port_b || b_ack !== e.port_b) begin
                    n_bad++;
                    $display("FAIL tie_order: grant %0d got aack=%b back=%b want %b %b", k, a_ack, b_ack, !e.port_b, e.port_b);
                end
                n_cmp++;
                if (fx_waddr !== e.addr || fx_data !== e.data) begin
                    n_bad++;
                    $display("FAIL tie_bus: grant %0d got waddr=%h data=%h want %h %h", k, fx_waddr, fx_data, e.addr, e.data);
                end
            end
        end
        a_req = 0; b_req = 0;
        @(negedge clk_sys);
        n_cmp++;
        if (busy !== 1'b0 || sbq.size() != 0) begin
            n_bad++;
            $display("FAIL tie_end: got busy=%b pending=%0d want 0 0", busy, sbq.size());
        end
    endtask

    task automatic test_late;
        @(negedge clk_sys);
        a_req = 1; a_we = 0; a_addr = 22'h000030;
        sbq.push_back('{1'b0, 1'b0, 22'h000030, 8'hD3});
        @(negedge clk_sys);
        n_cmp++;
        if (fx_rd !== 1'b1 || fx_raddr !== 22'h000030) begin
            n_bad++;
            $display("FAIL late_rd: got rd=%b raddr=%h want 1 000030", fx_rd, fx_raddr);
        end
        @(negedge clk_sys);
        b_req = 1; b_we = 1; b_addr = 22'h000040; b_wdata = 8'h77;
        sbq.push_back('{1'b1, 1'b1, 22'h000040, 8'h77});
        @(negedge clk_sys);
        e = sbq.pop_front();
        n_cmp++;
        if (a_ack !== 1'b1 || b_ack !== 1'b0 || a_rdata !== e.data || fx_wr !== 1'b0) begin
            n_bad++;
            $display("FAIL late_aack: got aack=%b back=%b ard=%h wr=%b want 1 0 %h 0", a_ack, b_ack, a_rdata, fx_wr, e.data);
        end
        n_cmp++;
        if (b_rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL late_other: got brd=%h want 00", b_rdata);
        end
        a_req = 0;
        @(negedge clk_sys);
        n_cmp++;
        if (busy !== 1'b0 || fx_wr !== 1'b0 || fx_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL late_idle: got busy=%b wr=%b rd=%b want 0 0 0", busy, fx_wr, fx_rd);
        end
        @(negedge clk_sys);
        n_cmp++;
        if (fx_wr !== 1'b1 || fx_rd !== 1'b0 || fx_waddr !== 22'h000040 || fx_data !== 8'h77) begin
            n_bad++;
            $display("FAIL late_bwr: got wr=%b rd=%b waddr=%h data=%h want 1 0 000040 77", fx_wr, fx_rd, fx_waddr, fx_data);
        end
        @(negedge clk_sys);
        e = sbq.pop_front();
        n_cmp++;
        if (b_ack !== e.port_b || a_ack !== 1'b0 || a_rdata !== 8'hD3) begin
            n_bad++;
            $display("FAIL late_back: got back=%b aack=%b ard=%h want 1 0 d3", b_ack, a_ack, a_rdata);
        end
        b_req = 0;
        @(negedge clk_sys);
    endtask

    task automatic test_reset_mid;
        @(negedge clk_sys);
        a_req = 1; a_we = 0; a_addr = 22'h000050;
        sbq.push_back('{1'b0, 1'b0, 22'h000050, 8'hB3});
        @(negedge clk_sys);
        n_cmp++;
        if (fx_rd !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre: got rd=%b want 1", fx_rd);
        end
        rst_n = 1'b0;
        a_req = 0;
        sbq.delete();
        #1;
        n_cmp++;
        if (fx_rd !== 1'b0 || busy !== 1'b0 || a_ack !== 1'b0 || a_rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_abort: got rd=%b busy=%b aack=%b ard=%h want 0 0 0 00", fx_rd, busy, a_ack, a_rdata);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_sys);
            n_cmp++;
            if (a_ack !== 1'b0 || b_ack !== 1'b0 || busy !== 1'b0 || fx_wr !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_hold: cycle %0d got aack=%b back=%b busy=%b wr=%b want 0 0 0 0", k, a_ack, b_ack, busy, fx_wr);
            end
        end
        rst_n = 1'b1;
        @(negedge clk_sys);
        a_req = 1; a_we = 1; a_addr = 22'h000060; a_wdata = 8'h99;
        sbq.push_back('{1'b0, 1'b1, 22'h000060, 8'h99});
        @(negedge clk_sys);
        n_cmp++;
        if (fx_wr !== 1'b1 || fx_waddr !== 22'h000060 || fx_data !== 8'h99) begin
            n_bad++;
            $display("FAIL rst_wr: got wr=%b waddr=%h data=%h want 1 000060 99", fx_wr, fx_waddr, fx_data);
        end
        @(negedge clk_sys);
        e = sbq.pop_front();
        n_cmp++;
        if (a_ack !== !e.port_b || b_ack !== e.port_b) begin
            n_bad++;
            $display("FAIL rst_ack: got aack=%b back=%b want 1 0", a_ack, b_ack);
        end
        a_req = 0;
        @(negedge clk_sys);
    endtask

    task automatic test_rdlat3;
        logic exp_ack;
        @(negedge clk_sys);
        c_req = 1; c_we = 0; c_addr = 22'h0000AB;
        sbq.push_back('{1'b0, 1'b0, 22'h0000AB, 8'h48});
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_sys);
            exp_ack = (k == 5);
            n_cmp++;
            if (c_ack !== exp_ack || d_ack !== 1'b0 || f3_rd !== (k == 1) || f3_wr !== 1'b0) begin
                n_bad++;
                $display("FAIL lat3_seq: cycle %0d got ack=%b back=%b rd=%b wr=%b want %b 0 %b 0", k, c_ack, d_ack, f3_rd, f3_wr, exp_ack, (k == 1));
            end
            if (k == 5) begin
                e = sbq.pop_front();
                n_cmp++;
                if (c_rdata !== e.data || d_rdata !== 8'h00 || busy3 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL lat3_data: got ard=%h brd=%h busy=%b want %h 00 1", c_rdata, d_rdata, busy3, e.data);
                end
                c_req = 0;
            end
        end
        @(negedge clk_sys);
        n_cmp++;
        if (busy3 !== 1'b0 || f3_waddr !== 22'd0 || f3_data !== 8'd0) begin
            n_bad++;
            $display("FAIL lat3_end: got busy=%b waddr=%h data=%h want 0 0 0", busy3, f3_waddr, f3_data);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_tie();
        test_late();
        test_reset_mid();
        test_rdlat3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
